// File: rtl/uart_pwm_cmd_decoder.sv
// rtl/uart_pwm_cmd_decoder.sv - UART frame decoder driving NUM_CH glitch-free PWM outputs
// Frames are HEADER, CH, DUTY, CSUM (CH^DUTY); duties are double-buffered and applied at period wrap.
module uart_pwm_cmd_decoder #(
  parameter int          NUM_CH       = 4,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int          TIMEOUT_CLKS = 4340
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Data,
  output logic [NUM_CH-1:0] o_PWM,
  output logic              o_Frame_OK,
  output logic              o_Frame_Err,
  output logic              o_Busy
);

  localparam int              GW       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]      CH_LIMIT = 9'(NUM_CH);

  typedef enum logic [1:0] {
    S_WAIT_HDR = 2'd0,
    S_GET_CH   = 2'd1,
    S_GET_DUTY = 2'd2,
    S_GET_CSUM = 2'd3
  } state_t;

  state_t            r_State;
  state_t            w_Next;
  logic [GW-1:0]     r_Gap;
  logic [7:0]        r_Ch;
  logic [7:0]        r_Duty;
  logic [7:0]        r_Pwm_Cnt;
  logic [7:0]        r_Shadow [NUM_CH];
  logic [7:0]        r_Active [NUM_CH];
  logic [NUM_CH-1:0] r_Pending;
  logic              w_Timeout;
  logic              w_Accept;
  logic              w_Reject;
  logic              w_Wrap;

  assign w_Wrap = (r_Pwm_Cnt == 8'hFF);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_State <= S_WAIT_HDR;
    else         r_State <= w_Next;
  end

  always_comb begin
    w_Next    = r_State;
    w_Accept  = 1'b0;
    w_Reject  = 1'b0;
    // A strobe arriving on the timeout cycle wins, so the byte is never lost.
    w_Timeout = (r_State != S_WAIT_HDR) && !i_RX_DV && (r_Gap == GAP_LAST);
    case (r_State)
      S_WAIT_HDR: if (i_RX_DV && i_RX_Data == HEADER) w_Next = S_GET_CH;
      S_GET_CH:   if (i_RX_DV) w_Next = S_GET_DUTY;
      S_GET_DUTY: if (i_RX_DV) w_Next = S_GET_CSUM;
      S_GET_CSUM: begin
        if (i_RX_DV) begin
          w_Next = S_WAIT_HDR;
          if (((r_Ch ^ r_Duty) == i_RX_Data) && ({1'b0, r_Ch} < CH_LIMIT)) w_Accept = 1'b1;
          else                                                             w_Reject = 1'b1;
        end
      end
    endcase
    if (w_Timeout) w_Next = S_WAIT_HDR;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Gap       <= '0;
      r_Ch        <= 8'd0;
      r_Duty      <= 8'd0;
      r_Pwm_Cnt   <= 8'd0;
      r_Pending   <= '0;
      o_PWM       <= '0;
      o_Frame_OK  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_Shadow[n] <= 8'd0;
        r_Active[n] <= 8'd0;
      end
    end else begin
      o_Frame_OK  <= w_Accept;
      o_Frame_Err <= w_Reject | w_Timeout;
      o_Busy      <= (w_Next != S_WAIT_HDR);
      if (i_RX_DV && r_State == S_GET_CH)   r_Ch   <= i_RX_Data;
      if (i_RX_DV && r_State == S_GET_DUTY) r_Duty <= i_RX_Data;
      if (i_RX_DV || w_Next == S_WAIT_HDR) r_Gap <= '0;
      else if (r_Gap != '1)                r_Gap <= r_Gap + 1'b1;
      r_Pwm_Cnt <= r_Pwm_Cnt + 8'd1;
      // Wrap copies the old shadow; an accept on the same edge re-arms pending for the next wrap.
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_Wrap && r_Pending[n]) begin
          r_Active[n]  <= r_Shadow[n];
          r_Pending[n] <= 1'b0;
        end
        if (w_Accept && r_Ch == 8'(n)) begin
          r_Shadow[n]  <= r_Duty;
          r_Pending[n] <= 1'b1;
        end
        o_PWM[n] <= (r_Pwm_Cnt < r_Active[n]);
      end
    end
  end

endmodule
